// File: rtl/display_scan_if.sv
// Bundle between value-producing logic and the 7-segment scan controller.
// The master drives digit data and controls; the slave drives the display pins.
interface display_scan_if;
  logic        enable;
  logic [7:0]  digit_en;
  logic [31:0] digits_hex;
  logic [7:0]  dp_in;
  logic [7:0]  anodo;
  logic [6:0]  segmentos;
  logic        dp;
  logic [2:0]  digit_idx;
  logic        frame_done;

  modport master (
    output enable, digit_en, digits_hex, dp_in,
    input  anodo, segmentos, dp, digit_idx, frame_done
  );

  modport slave (
    input  enable, digit_en, digits_hex, dp_in,
    output anodo, segmentos, dp, digit_idx, frame_done
  );
endinterface

// File: rtl/display_scan_controller.sv
// Time-multiplexed 8-digit common-anode 7-segment scanner with per-slot
// blanking, digit masking and hex decode; all outputs registered.
module display_scan_controller #(
  parameter int CLK_HZ       = 100000000,
  parameter int REFRESH_HZ   = 10000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic          clk,
  input  logic          reset,
  display_scan_if.slave bus
);
  localparam int DIV = CLK_HZ / REFRESH_HZ;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST      = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  localparam state_t SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    idx_reg, idx_next;
  logic [7:0]    anodo_reg, anodo_next;
  logic [6:0]    seg_reg, seg_next;
  logic          dp_reg, dp_next;
  logic          frame_reg, frame_next;
  logic [3:0]    nibble [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nibble
      assign nibble[gi] = bus.digits_hex[4*gi +: 4];
    end
  endgenerate

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) r = 3'(i);
    return r;
  endfunction

  // Nearest set bit strictly above cur, wrapping; cur itself is the last candidate.
  function automatic logic [2:0] next_set(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] r;
    logic [2:0] j;
    r = cur;
    for (int k = 8; k >= 1; k--) begin
      j = cur + 3'(k);
      if (m[j]) r = j;
    end
    return r;
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= 3'd0;
      anodo_reg <= 8'hFF;
      seg_reg   <= 7'h7F;
      dp_reg    <= 1'b1;
      frame_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      anodo_reg <= anodo_next;
      seg_reg   <= seg_next;
      dp_reg    <= dp_next;
      frame_reg <= frame_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    frame_next = 1'b0;
    if (!bus.enable) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|bus.digit_en) begin
            idx_next   = lowest_set(bus.digit_en);
            cnt_next   = '0;
            state_next = SLOT_START;
          end
        end
        default: begin
          if (cnt_reg == LAST) begin
            cnt_next = '0;
            if (bus.digit_en == 8'h00) begin
              state_next = IDLE;
            end else begin
              idx_next   = next_set(bus.digit_en, idx_reg);
              state_next = SLOT_START;
              frame_next = (idx_next <= idx_reg);
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_next == BLANK_END) state_next = SHOW;
          end
        end
      endcase
    end

    // Outputs are computed from the next state so they move with it.
    anodo_next = 8'hFF;
    seg_next   = 7'h7F;
    dp_next    = 1'b1;
    if (state_next == SHOW) begin
      anodo_next = ~(8'h01 << idx_next);
      seg_next   = hex7(nibble[idx_next]);
      dp_next    = ~bus.dp_in[idx_next];
    end
  end

  assign bus.anodo      = anodo_reg;
  assign bus.segmentos  = seg_reg;
  assign bus.dp         = dp_reg;
  assign bus.digit_idx  = idx_reg;
  assign bus.frame_done = frame_reg;
endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with DIV=10, BLANK_CYCLES=2;
// outputs are sampled on the falling clock edge.
module tb_display_scan_controller;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  display_scan_if bus ();

  display_scan_controller #(
    .CLK_HZ(1000), .REFRESH_HZ(100), .BLANK_CYCLES(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dark(input string tag);
    check({tag, ".anodo"}, 32'(bus.anodo), 32'hFF);
    check({tag, ".seg"}, 32'(bus.segmentos), 32'h7F);
    check({tag, ".dp"}, 32'(bus.dp), 32'h1);
    check({tag, ".frame"}, 32'(bus.frame_done), 32'h0);
  endtask

  // Cycle c (1..10) of a slot: cycles 1-2 blank, 3-10 show.
  task automatic check_cycle(input int c, input logic [2:0] idx, input logic [7:0] an,
                             input logic [6:0] seg, input logic dpv, input logic fd_first);
    check("idx", 32'(bus.digit_idx), 32'(idx));
    check("frame", 32'(bus.frame_done), (c == 1) ? 32'(fd_first) : 32'h0);
    if (c <= 2) begin
      check("blank.anodo", 32'(bus.anodo), 32'hFF);
      check("blank.seg", 32'(bus.segmentos), 32'h7F);
      check("blank.dp", 32'(bus.dp), 32'h1);
    end else begin
      check("show.anodo", 32'(bus.anodo), 32'(an));
      check("show.seg", 32'(bus.segmentos), 32'(seg));
      check("show.dp", 32'(bus.dp), 32'(dpv));
    end
  endtask

  task automatic expect_slot(input logic [2:0] idx, input logic [7:0] an,
                             input logic [6:0] seg, input logic dpv, input logic fd_first);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check_cycle(c, idx, an, seg, dpv, fd_first);
    end
    $display("slot idx=%0d anodo=%h seg=%b dp=%b checks=%0d errors=%0d",
             idx, an, seg, dpv, checks, errors);
  endtask

  task automatic go_idle();
    bus.enable = 1'b0;
    @(negedge clk);
    check_dark("go_idle");
  endtask

  initial begin
    reset          = 1'b1;
    bus.enable     = 1'b0;
    bus.digit_en   = 8'h00;
    bus.digits_hex = 32'h0;
    bus.dp_in      = 8'h00;

    // Reset and idle with enable low
    repeat (3) @(negedge clk);
    check_dark("reset");
    check("reset.idx", 32'(bus.digit_idx), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_dark("idle");
    end
    $display("reset/idle done checks=%0d errors=%0d", checks, errors);

    // Two-digit scan: 1 on digit 0, 2 on digit 1
    bus.digits_hex = 32'h0000_0021;
    bus.digit_en   = 8'h03;
    bus.enable     = 1'b1;
    expect_slot(3'd0, 8'hFE, HEX[1], 1'b1, 1'b0);
    expect_slot(3'd1, 8'hFD, HEX[2], 1'b1, 1'b0);
    expect_slot(3'd0, 8'hFE, HEX[1], 1'b1, 1'b1);
    expect_slot(3'd1, 8'hFD, HEX[2], 1'b1, 1'b0);
    expect_slot(3'd0, 8'hFE, HEX[1], 1'b1, 1'b1);

    // Sparse mask 0x81
    go_idle();
    bus.digits_hex = 32'h8000_0001;
    bus.digit_en   = 8'h81;
    bus.enable     = 1'b1;
    expect_slot(3'd0, 8'hFE, HEX[1], 1'b1, 1'b0);
    expect_slot(3'd7, 8'h7F, HEX[8], 1'b1, 1'b0);
    expect_slot(3'd0, 8'hFE, HEX[1], 1'b1, 1'b1);
    expect_slot(3'd7, 8'h7F, HEX[8], 1'b1, 1'b0);

    // Decode and decimal point sweep on digit 0
    go_idle();
    bus.digit_en = 8'h01;
    bus.dp_in    = 8'h01;
    for (int v = 0; v < 16; v++) begin
      bus.digits_hex = 32'(v);
      bus.enable     = 1'b1;
      expect_slot(3'd0, 8'hFE, HEX[v], 1'b0, (v != 0));
    end

    // Mask change mid-slot takes effect at the slot end
    go_idle();
    bus.dp_in      = 8'h00;
    bus.digits_hex = 32'h0000_0021;
    bus.digit_en   = 8'h03;
    bus.enable     = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check_cycle(c, 3'd0, 8'hFE, HEX[1], 1'b1, 1'b0);
      if (c == 5) bus.digit_en = 8'h04;
    end
    expect_slot(3'd2, 8'hFB, HEX[0], 1'b1, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check_cycle(c, 3'd2, 8'hFB, HEX[0], 1'b1, 1'b1);
      if (c == 5) bus.digit_en = 8'h00;
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_dark("mask_zero");
    end
    $display("mask change done checks=%0d errors=%0d", checks, errors);

    // Enable dropped mid-SHOW, then restart from slot beginning
    bus.digit_en = 8'h01;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check_cycle(c, 3'd0, 8'hFE, HEX[1], 1'b1, 1'b0);
    end
    bus.enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_dark("disable");
    end
    bus.enable = 1'b1;
    expect_slot(3'd0, 8'hFE, HEX[1], 1'b1, 1'b0);

    // Asynchronous reset between clock edges during SHOW
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check_cycle(c, 3'd0, 8'hFE, HEX[1], 1'b1, 1'b1);
    end
    #2;
    reset = 1'b1;
    #1;
    check_dark("async_reset");
    check("async_reset.idx", 32'(bus.digit_idx), 32'h0);
    @(negedge clk);
    check_dark("reset_held");
    reset = 1'b0;
    expect_slot(3'd0, 8'hFE, HEX[1], 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
